// File: rtl/hmmm_loader.sv
// hmmm_loader: streams host program words into Hmmm core RAM via the MAR/RAM load
// strobes, then releases the core and tracks halt. Define HMMM_LOADER_CHECKSUM_EN for checksum verification.
module hmmm_loader #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic [ADDR_W-1:0] load_base,
    input  logic [ADDR_W:0]   load_len,
    input  logic              host_valid,
    input  logic [DATA_W-1:0] host_data,
    output logic              host_ready,
    output logic [DATA_W-1:0] bus_out,
    output logic              bus_oe,
    output logic              pgrm_addr,
    output logic              pgrm_data,
    output logic              cpu_rst,
    input  logic              cpu_halt,
    output logic              busy,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT, S_ADDR, S_DATA, S_RUN, S_HALTED
`ifdef HMMM_LOADER_CHECKSUM_EN
        , S_CHECK, S_ERROR
`endif
    } state_t;

    state_t            state, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   rem_q;
    logic [DATA_W-1:0] data_q;
    logic              start_ok;
    logic              accept_word;
    state_t            after_start;
    state_t            after_last;

`ifdef HMMM_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q;

    assign start_ok    = load_start && (state inside {S_IDLE, S_RUN, S_HALTED, S_ERROR});
    assign after_start = (load_len != '0) ? S_WAIT : S_CHECK;
    assign after_last  = S_CHECK;
    assign error       = (state == S_ERROR);
`else
    assign start_ok    = load_start && (state inside {S_IDLE, S_RUN, S_HALTED});
    assign after_start = (load_len != '0) ? S_WAIT : S_RUN;
    assign after_last  = S_RUN;
    assign error       = 1'b0;
`endif

    assign accept_word = (state == S_WAIT) && host_valid;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            addr_q <= '0;
            rem_q  <= '0;
            data_q <= '0;
`ifdef HMMM_LOADER_CHECKSUM_EN
            sum_q  <= '0;
`endif
        end else begin
            state <= state_d;
            if (start_ok) begin
                addr_q <= load_base;
                rem_q  <= load_len;
`ifdef HMMM_LOADER_CHECKSUM_EN
                sum_q  <= '0;
`endif
            end else if (accept_word) begin
                data_q <= host_data;
`ifdef HMMM_LOADER_CHECKSUM_EN
                sum_q  <= sum_q + host_data;
`endif
            end else if (state == S_DATA) begin
                // Address wraps naturally at 2^ADDR_W.
                addr_q <= addr_q + 1'b1;
                rem_q  <= rem_q - 1'b1;
            end
        end
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        state_d = state;
        case (state)
            S_IDLE, S_HALTED: if (start_ok) state_d = after_start;
            S_RUN: begin
                // A simultaneous load request takes priority over halt.
                if (start_ok)      state_d = after_start;
                else if (cpu_halt) state_d = S_HALTED;
            end
            S_WAIT: if (accept_word) state_d = S_ADDR;
            S_ADDR: state_d = S_DATA;
            S_DATA: state_d = (rem_q == (ADDR_W+1)'(1)) ? after_last : S_WAIT;
`ifdef HMMM_LOADER_CHECKSUM_EN
            S_CHECK: if (host_valid) state_d = (host_data == sum_q) ? S_RUN : S_ERROR;
            S_ERROR: if (start_ok) state_d = after_start;
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        host_ready = 1'b0;
        bus_out    = '0;
        bus_oe     = 1'b0;
        pgrm_addr  = 1'b0;
        pgrm_data  = 1'b0;
        cpu_rst    = 1'b1;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            S_WAIT: begin
                host_ready = 1'b1;
                busy       = 1'b1;
            end
            S_ADDR: begin
                bus_out   = DATA_W'(addr_q);
                bus_oe    = 1'b1;
                pgrm_addr = 1'b1;
                busy      = 1'b1;
            end
            S_DATA: begin
                bus_out   = data_q;
                bus_oe    = 1'b1;
                pgrm_data = 1'b1;
                busy      = 1'b1;
            end
`ifdef HMMM_LOADER_CHECKSUM_EN
            S_CHECK: begin
                host_ready = 1'b1;
                busy       = 1'b1;
            end
`endif
            S_RUN:    cpu_rst = 1'b0;
            S_HALTED: begin
                cpu_rst = 1'b0;
                done    = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_hmmm_loader.sv
// tb_hmmm_loader: table-driven and directed checks for hmmm_loader (default widths).
// Checksum sequences are exercised when HMMM_LOADER_CHECKSUM_EN is defined.
module tb_hmmm_loader;

    typedef struct packed {
        logic        rdy;
        logic        pa;
        logic        pd;
        logic        oe;
        logic        crst;
        logic        busy;
        logic        done;
        logic        err;
        logic [15:0] bus;
    } out_t;

    typedef struct {
        logic        ls;
        logic [7:0]  base;
        logic [8:0]  len;
        logic        hv;
        logic [15:0] hd;
        logic        halt;
        out_t        exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_start;
    logic [7:0]  load_base;
    logic [8:0]  load_len;
    logic        host_valid;
    logic [15:0] host_data;
    logic        host_ready;
    logic [15:0] bus_out;
    logic        bus_oe;
    logic        pgrm_addr;
    logic        pgrm_data;
    logic        cpu_rst;
    logic        cpu_halt;
    logic        busy;
    logic        done;
    logic        error;

    int n_checks = 0;
    int n_errors = 0;

    hmmm_loader #(.DATA_W(16), .ADDR_W(8)) dut (
        .clk(clk), .rst(rst),
        .load_start(load_start), .load_base(load_base), .load_len(load_len),
        .host_valid(host_valid), .host_data(host_data), .host_ready(host_ready),
        .bus_out(bus_out), .bus_oe(bus_oe), .pgrm_addr(pgrm_addr), .pgrm_data(pgrm_data),
        .cpu_rst(cpu_rst), .cpu_halt(cpu_halt), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    out_t act;
    assign act = {host_ready, pgrm_addr, pgrm_data, bus_oe, cpu_rst, busy, done, error, bus_out};

    function automatic out_t mk(logic rdy, logic pa, logic pd, logic oe, logic crst,
                                logic bsy, logic dn, logic er, logic [15:0] b);
        out_t o;
        o = '{rdy: rdy, pa: pa, pd: pd, oe: oe, crst: crst, busy: bsy, done: dn, err: er, bus: b};
        return o;
    endfunction

    function automatic out_t e_idle();               return mk(0,0,0,0,1,0,0,0,16'h0); endfunction
    function automatic out_t e_wait();               return mk(1,0,0,0,1,1,0,0,16'h0); endfunction
    function automatic out_t e_addr(logic [7:0] a);  return mk(0,1,0,1,1,1,0,0,{8'h00, a}); endfunction
    function automatic out_t e_data(logic [15:0] d); return mk(0,0,1,1,1,1,0,0,d); endfunction
    function automatic out_t e_run();                return mk(0,0,0,0,0,0,0,0,16'h0); endfunction
    function automatic out_t e_halt();               return mk(0,0,0,0,0,0,1,0,16'h0); endfunction
`ifdef HMMM_LOADER_CHECKSUM_EN
    function automatic out_t e_check();              return mk(1,0,0,0,1,1,0,0,16'h0); endfunction
    function automatic out_t e_err();                return mk(0,0,0,0,1,0,0,1,16'h0); endfunction
`endif

    task automatic check(input string name, input out_t exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got rdy/pa/pd/oe/crst/busy/done/err/bus=%b%b%b%b%b%b%b%b/%h expected %b%b%b%b%b%b%b%b/%h",
                     name, act.rdy, act.pa, act.pd, act.oe, act.crst, act.busy, act.done, act.err, act.bus,
                     exp.rdy, exp.pa, exp.pd, exp.oe, exp.crst, exp.busy, exp.done, exp.err, exp.bus);
        end
    endtask

    // Inputs are already driven; compare at the falling edge, then advance past the next rising edge.
    task automatic step(input string name, input out_t exp);
        @(negedge clk);
        check(name, exp);
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [7:0] base, input logic [8:0] len, input out_t exp_now);
        load_start = 1'b1;
        load_base  = base;
        load_len   = len;
        step("start", exp_now);
        load_start = 1'b0;
    endtask

    task automatic word(input logic [7:0] a, input logic [15:0] d);
        host_valid = 1'b1;
        host_data  = d;
        step("word_wait", e_wait());
        host_valid = 1'b0;
        host_data  = 16'h0;
        step("word_addr", e_addr(a));
        step("word_data", e_data(d));
    endtask

    task automatic finish_load(input logic [15:0] sum);
`ifdef HMMM_LOADER_CHECKSUM_EN
        host_valid = 1'b1;
        host_data  = sum;
        step("check_word", e_check());
        host_valid = 1'b0;
        host_data  = 16'h0;
`else
        host_data = sum & 16'h0;
`endif
    endtask

    vec_t tbl[$];

    function automatic vec_t v(logic ls, logic [7:0] b, logic [8:0] l, logic hv,
                               logic [15:0] hd, logic h, out_t e);
        vec_t r;
        r = '{ls: ls, base: b, len: l, hv: hv, hd: hd, halt: h, exp: e};
        return r;
    endfunction

    initial begin
        rst = 1'b1; load_start = 1'b0; load_base = '0; load_len = '0;
        host_valid = 1'b0; host_data = '0; cpu_halt = 1'b0;

        // Basic load: base 0, three words, host_valid held high throughout.
        tbl.push_back(v(1, 8'h00, 9'd3, 1, 16'h6001, 0, e_idle()));
        tbl.push_back(v(0, 8'h00, 9'd0, 1, 16'h6001, 0, e_wait()));
        tbl.push_back(v(0, 8'h00, 9'd0, 1, 16'h6102, 0, e_addr(8'h00)));
        tbl.push_back(v(0, 8'h00, 9'd0, 1, 16'h6102, 0, e_data(16'h6001)));
        tbl.push_back(v(0, 8'h00, 9'd0, 1, 16'h6102, 0, e_wait()));
        tbl.push_back(v(0, 8'h00, 9'd0, 1, 16'h0000, 0, e_addr(8'h01)));
        tbl.push_back(v(0, 8'h00, 9'd0, 1, 16'h0000, 0, e_data(16'h6102)));
        tbl.push_back(v(0, 8'h00, 9'd0, 1, 16'h0000, 0, e_wait()));
        tbl.push_back(v(0, 8'h00, 9'd0, 1, 16'h0000, 0, e_addr(8'h02)));
        tbl.push_back(v(0, 8'h00, 9'd0, 1, 16'hC103, 0, e_data(16'h0000)));
`ifdef HMMM_LOADER_CHECKSUM_EN
        tbl.push_back(v(0, 8'h00, 9'd0, 1, 16'hC103, 0, e_check()));
`endif
        tbl.push_back(v(0, 8'h00, 9'd0, 0, 16'h0000, 1, e_run()));
        tbl.push_back(v(0, 8'h00, 9'd0, 0, 16'h0000, 0, e_halt()));
        tbl.push_back(v(0, 8'h00, 9'd0, 0, 16'h0000, 0, e_halt()));

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 5; i++) step("reset_idle", e_idle());

        foreach (tbl[i]) begin
            load_start = tbl[i].ls;
            load_base  = tbl[i].base;
            load_len   = tbl[i].len;
            host_valid = tbl[i].hv;
            host_data  = tbl[i].hd;
            cpu_halt   = tbl[i].halt;
            step($sformatf("table[%0d]", i), tbl[i].exp);
        end
        load_start = 1'b0; host_valid = 1'b0; cpu_halt = 1'b0;

        // Restart from HALTED with an address range that wraps past 0xFF.
        start(8'hFE, 9'd3, e_halt());
        word(8'hFE, 16'h1111);
        word(8'hFF, 16'h2222);
        word(8'h00, 16'h3333);
        finish_load(16'h6666);
        step("wrap_run", e_run());

        // load_start and cpu_halt together in RUN: the new load wins, done stays low.
        cpu_halt = 1'b1;
        start(8'h10, 9'd2, e_run());
        cpu_halt = 1'b0;

        // Host stalls four cycles mid-load; a stray load_start in WAIT is ignored.
        word(8'h10, 16'h0A0A);
        load_start = 1'b1; load_base = 8'h80; load_len = 9'd1;
        step("stall_ignore_start", e_wait());
        load_start = 1'b0;
        for (int i = 0; i < 3; i++) step("stall_wait", e_wait());
        word(8'h11, 16'h0B0B);
        finish_load(16'h1515);
        cpu_halt = 1'b1;
        step("stall_run", e_run());
        cpu_halt = 1'b0;
        step("stall_halted", e_halt());

        // Zero-length load.
        start(8'h00, 9'd0, e_halt());
`ifdef HMMM_LOADER_CHECKSUM_EN
        finish_load(16'h0000);
`endif
        step("len0_run", e_run());
        step("len0_quiet", e_run());

`ifdef HMMM_LOADER_CHECKSUM_EN
        // Correct checksum releases the core.
        start(8'h20, 9'd2, e_run());
        word(8'h20, 16'h8001);
        word(8'h21, 16'h8002);
        finish_load(16'h0003);
        step("sum_ok_run", e_run());

        // Wrong checksum parks in ERROR with the core held in reset.
        start(8'h20, 9'd2, e_run());
        word(8'h20, 16'h8001);
        word(8'h21, 16'h8002);
        finish_load(16'h0004);
        step("sum_bad_err", e_err());
        step("sum_bad_hold", e_err());
        start(8'h00, 9'd0, e_err());
        step("err_cleared", e_check());
        finish_load(16'h0000);
        step("err_recover_run", e_run());
`endif

        // Reset in the middle of a load abandons it.
        start(8'h40, 9'd2, e_run());
        step("midload_wait", e_wait());
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        step("midload_reset", e_idle());

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
